fpu_seq: RTL and testbench

- Sequential, parametrised successor to the combinational `fpu_top`.
- Same op encoding: 00 add, 01 sub, 10 mul, 11 div.
- Operands and results use a generic IEEE-754-style format of width 1+EXP_W+MAN_W.
- Transfers use valid/ready handshakes; one operation is in flight at a time. Division runs as an iterative restoring divider.

---
 rtl/fpu_seq.sv | 210 +++++++++++++++++++++
 tb/tb_fpu_seq.sv | 169 ++++++++++++++++
 2 files changed

// File: rtl/fpu_seq.sv
// fpu_seq: sequential IEEE-754-style add/sub/mul/div behind valid/ready handshakes.
// Truncating arithmetic, denormals flushed to zero, restoring divider at one quotient bit per cycle.
module fpu_seq #(
    parameter int EXP_W = 8,
    parameter int MAN_W = 23
) (
    input  logic                 clk,
    input  logic                 rst_n,
    input  logic                 in_valid,
    output logic                 in_ready,
    input  logic [1:0]           op,
    input  logic [EXP_W+MAN_W:0] a,
    input  logic [EXP_W+MAN_W:0] b,
    output logic                 out_valid,
    input  logic                 out_ready,
    output logic [EXP_W+MAN_W:0] result,
    output logic                 error,
    output logic                 underflow,
    output logic                 overflow
);
    localparam int W    = 1 + EXP_W + MAN_W;
    localparam int MW   = 2 * MAN_W + 2;
    localparam int LZW  = $clog2(MW + 1);
    localparam int XW   = EXP_W + LZW + 2;
    localparam int CW   = $clog2(MAN_W + 4);
    localparam int BIAS = 2 ** (EXP_W - 1) - 1;
    localparam int EMAX = 2 ** EXP_W - 1;

    localparam logic [2:0] S_IDLE   = 3'd0;
    localparam logic [2:0] S_UNPACK = 3'd1;
    localparam logic [2:0] S_EXEC   = 3'd2;
    localparam logic [2:0] S_NORM   = 3'd3;
    localparam logic [2:0] S_DONE   = 3'd4;

    localparam logic [W-1:0]         QNAN   = {1'b0, {EXP_W{1'b1}}, 1'b1, {(MAN_W-1){1'b0}}};
    localparam logic signed [XW-1:0] BIAS_X = XW'(BIAS);
    localparam logic signed [XW-1:0] EMAX_X = XW'(EMAX);

    logic [2:0]              r_state;
    logic [1:0]              r_op;
    logic [W-1:0]            r_a, r_b;
    logic                    r_sa, r_sb;
    logic [EXP_W-1:0]        r_ea, r_eb;
    logic [MAN_W:0]          r_ma, r_mb;
    logic                    r_special;
    logic [W-1:0]            r_spec_res;
    logic [MAN_W+1:0]        r_rem;
    logic [MAN_W+2:0]        r_quo;
    logic [CW-1:0]           r_cnt;
    logic                    r_sign;
    logic signed [XW-1:0]    r_exp;
    logic [MW-1:0]           r_mant;
    logic [W-1:0]            r_result;
    logic                    r_error, r_underflow, r_overflow, r_out_valid;

    logic [EXP_W-1:0]        w_ua_e, w_ub_e;
    logic                    w_ua_zero, w_ub_zero, w_ub_s, w_nan_in, w_div0;
    logic [MAN_W:0]          w_ua_m, w_ub_m;
    logic                    w_a_big, w_sx, w_add_sign;
    logic [EXP_W-1:0]        w_ex, w_shamt;
    logic [LZW-1:0]          w_shamt_c;
    logic [MAN_W:0]          w_mx, w_my;
    logic [MAN_W+4:0]        w_ext_x, w_ext_y, w_sum;
    logic [MW-1:0]           w_prod;
    logic signed [XW-1:0]    w_ea_x, w_eb_x, w_ex_x, w_mul_exp, w_div_exp, w_nexp;
    logic                    w_qbit, w_found, w_is_zero;
    logic [MAN_W+1:0]        w_rem_sub;
    logic [MAN_W+3:0]        w_quo_next;
    logic [LZW-1:0]          w_lz;
    logic [MAN_W-1:0]        w_frac;

    assign in_ready  = (r_state == S_IDLE);
    assign out_valid = r_out_valid;
    assign result    = r_result;
    assign error     = r_error;
    assign underflow = r_underflow;
    assign overflow  = r_overflow;

    // Field split and special-operand detection; sub folds into add by flipping sign(b).
    always_comb begin
        w_ua_e    = r_a[W-2:MAN_W];
        w_ub_e    = r_b[W-2:MAN_W];
        w_ua_zero = (w_ua_e == '0);
        w_ub_zero = (w_ub_e == '0);
        w_ua_m    = w_ua_zero ? '0 : {1'b1, r_a[MAN_W-1:0]};
        w_ub_m    = w_ub_zero ? '0 : {1'b1, r_b[MAN_W-1:0]};
        w_ub_s    = r_b[W-1] ^ (r_op == 2'b01);
        w_nan_in  = (&w_ua_e) | (&w_ub_e);
        w_div0    = (r_op == 2'b11) && w_ub_zero;
    end

    always_comb begin
        w_a_big    = {r_ea, r_ma} >= {r_eb, r_mb};
        w_ex       = w_a_big ? r_ea : r_eb;
        w_mx       = w_a_big ? r_ma : r_mb;
        w_my       = w_a_big ? r_mb : r_ma;
        w_sx       = w_a_big ? r_sa : r_sb;
        w_shamt    = w_ex - (w_a_big ? r_eb : r_ea);
        w_shamt_c  = (int'(w_shamt) > MAN_W + 3) ? LZW'(MAN_W + 3) : LZW'(w_shamt);
        w_ext_x    = {1'b0, w_mx, 3'b000};
        w_ext_y    = {1'b0, w_my, 3'b000} >> w_shamt_c;
        w_sum      = (r_sa == r_sb) ? (w_ext_x + w_ext_y) : (w_ext_x - w_ext_y);
        w_add_sign = (w_sum == '0) ? 1'b0 : w_sx;
        w_prod     = {{(MAN_W+1){1'b0}}, r_ma} * {{(MAN_W+1){1'b0}}, r_mb};
        w_ea_x     = XW'(r_ea);
        w_eb_x     = XW'(r_eb);
        w_ex_x     = XW'(w_ex);
        w_mul_exp  = w_ea_x + w_eb_x - BIAS_X;
        w_div_exp  = w_ea_x - w_eb_x + BIAS_X;
        w_qbit     = (r_rem >= {1'b0, r_mb});
        w_rem_sub  = w_qbit ? (r_rem - {1'b0, r_mb}) : r_rem;
        w_quo_next = {r_quo, w_qbit};
    end

    // All paths share one mantissa frame: bit 2*MAN_W has unit weight.
    always_comb begin
        w_lz    = '0;
        w_found = 1'b0;
        for (int unsigned i = 0; i < MW; i++) begin
            if (!w_found && r_mant[MW-1-i]) begin
                w_lz    = LZW'(i);
                w_found = 1'b1;
            end
        end
        w_is_zero = (r_mant == '0);
        w_nexp    = r_exp + XW'(1) - XW'(w_lz);
        w_frac    = MAN_W'((r_mant << w_lz) >> (MAN_W + 1));
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_state <= S_IDLE;      r_op <= '0;        r_a <= '0;        r_b <= '0;
            r_sa <= 1'b0;           r_sb <= 1'b0;      r_ea <= '0;       r_eb <= '0;
            r_ma <= '0;             r_mb <= '0;        r_special <= 1'b0; r_spec_res <= '0;
            r_rem <= '0;            r_quo <= '0;       r_cnt <= '0;
            r_sign <= 1'b0;         r_exp <= '0;       r_mant <= '0;
            r_result <= '0;         r_error <= 1'b0;   r_underflow <= 1'b0;
            r_overflow <= 1'b0;     r_out_valid <= 1'b0;
        end else begin
            case (r_state)
                S_IDLE: if (in_valid) begin
                    r_op <= op;  r_a <= a;  r_b <= b;
                    r_result <= '0;  r_error <= 1'b0;  r_underflow <= 1'b0;  r_overflow <= 1'b0;
                    r_state <= S_UNPACK;
                end
                S_UNPACK: begin
                    r_sa <= r_a[W-1];  r_sb <= w_ub_s;
                    r_ea <= w_ua_e;    r_eb <= w_ub_e;
                    r_ma <= w_ua_m;    r_mb <= w_ub_m;
                    r_special  <= w_nan_in | w_div0;
                    r_spec_res <= (w_nan_in || w_ua_zero) ? QNAN
                                : {r_a[W-1] ^ r_b[W-1], {EXP_W{1'b1}}, {MAN_W{1'b0}}};
                    r_rem <= {1'b0, w_ua_m};
                    r_quo <= '0;
                    r_cnt <= '0;
                    r_state <= S_EXEC;
                end
                S_EXEC: if (r_op == 2'b11) begin
                    r_rem <= w_rem_sub << 1;
                    r_quo <= w_quo_next[MAN_W+2:0];
                    r_cnt <= r_cnt + 1'b1;
                    if (r_cnt == CW'(MAN_W + 3)) begin
                        r_sign  <= r_sa ^ r_sb;
                        r_exp   <= w_div_exp;
                        r_mant  <= {1'b0, w_quo_next, {(MAN_W-3){1'b0}}};
                        r_state <= S_NORM;
                    end
                end else begin
                    if (r_op[1]) begin
                        r_sign <= r_sa ^ r_sb;
                        r_exp  <= w_mul_exp;
                        r_mant <= w_prod;
                    end else begin
                        r_sign <= w_add_sign;
                        r_exp  <= w_ex_x;
                        r_mant <= {w_sum, {(MAN_W-3){1'b0}}};
                    end
                    r_state <= S_NORM;
                end
                S_NORM: begin
                    if (r_special) begin
                        r_result <= r_spec_res;
                        r_error  <= 1'b1;
                    end else if (w_is_zero) begin
                        r_result <= {r_sign, {(W-1){1'b0}}};
                    end else if (w_nexp >= EMAX_X) begin
                        r_result   <= {r_sign, {EXP_W{1'b1}}, {MAN_W{1'b0}}};
                        r_overflow <= 1'b1;
                    end else if (w_nexp <= 0) begin
                        r_result    <= {r_sign, {(W-1){1'b0}}};
                        r_underflow <= 1'b1;
                    end else begin
                        r_result <= {r_sign, w_nexp[EXP_W-1:0], w_frac};
                    end
                    r_state <= S_DONE;
                end
                // out_valid is registered one cycle into DONE, after result/flags have settled.
                S_DONE: begin
                    if (!r_out_valid) begin
                        r_out_valid <= 1'b1;
                    end else if (out_ready) begin
                        r_out_valid <= 1'b0;
                        r_state     <= S_IDLE;
                    end
                end
                default: r_state <= S_IDLE;
            endcase
        end
    end
endmodule

// File: tb/tb_fpu_seq.sv
// Directed self-checking bench for fpu_seq: default single format plus an EXP_W=5/MAN_W=10 instance.
module tb_fpu_seq;
    logic        clk = 1'b0;
    logic        rst_n;
    int          n_checks = 0;
    int          n_errors = 0;

    logic        f_in_valid, f_in_ready, f_out_valid, f_out_ready;
    logic [1:0]  f_op;
    logic [31:0] f_a, f_b, f_result;
    logic        f_error, f_underflow, f_overflow;

    logic        h_in_valid, h_in_ready, h_out_valid, h_out_ready;
    logic [1:0]  h_op;
    logic [15:0] h_a, h_b, h_result;
    logic        h_error, h_underflow, h_overflow;

    always #5 clk = ~clk;

    fpu_seq #(.EXP_W(8), .MAN_W(23)) u_dut (
        .clk(clk), .rst_n(rst_n), .in_valid(f_in_valid), .in_ready(f_in_ready),
        .op(f_op), .a(f_a), .b(f_b), .out_valid(f_out_valid), .out_ready(f_out_ready),
        .result(f_result), .error(f_error), .underflow(f_underflow), .overflow(f_overflow)
    );

    fpu_seq #(.EXP_W(5), .MAN_W(10)) u_dut_h (
        .clk(clk), .rst_n(rst_n), .in_valid(h_in_valid), .in_ready(h_in_ready),
        .op(h_op), .a(h_a), .b(h_b), .out_valid(h_out_valid), .out_ready(h_out_ready),
        .result(h_result), .error(h_error), .underflow(h_underflow), .overflow(h_overflow)
    );

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_checks++;
        assert (obs === exp) else begin
            n_errors++;
            $error("FAIL %s: observed %h expected %h", tag, obs, exp);
        end
    endtask

    task automatic issue32(input logic [1:0] o, input logic [31:0] x, input logic [31:0] y);
        int n = 0;
        while (!f_in_ready && n < 200) begin @(posedge clk); #1; n++; end
        check("issue32 in_ready", f_in_ready, 1);
        f_op = o; f_a = x; f_b = y; f_in_valid = 1'b1;
        @(posedge clk); #1;
        f_in_valid = 1'b0;
    endtask

    task automatic wait_out32(output int lat);
        lat = 0;
        while (!f_out_valid && lat < 200) begin @(posedge clk); #1; lat++; end
    endtask

    task automatic release32();
        f_out_ready = 1'b1;
        @(posedge clk); #1;
        f_out_ready = 1'b0;
        check("release32 out_valid", f_out_valid, 0);
    endtask

    task automatic do32(input string tag, input logic [1:0] o, input logic [31:0] x, input logic [31:0] y,
                        input logic [31:0] er, input logic [2:0] eflags, input int elat);
        int lat;
        issue32(o, x, y);
        wait_out32(lat);
        check({tag, " latency"}, lat, elat);
        check({tag, " result"}, f_result, er);
        check({tag, " err/unf/ovf"}, {f_error, f_underflow, f_overflow}, eflags);
        release32();
    endtask

    task automatic do16(input string tag, input logic [1:0] o, input logic [15:0] x, input logic [15:0] y,
                        input logic [15:0] er, input logic [2:0] eflags, input int elat);
        int lat = 0;
        int n = 0;
        while (!h_in_ready && n < 200) begin @(posedge clk); #1; n++; end
        h_op = o; h_a = x; h_b = y; h_in_valid = 1'b1;
        @(posedge clk); #1;
        h_in_valid = 1'b0;
        while (!h_out_valid && lat < 200) begin @(posedge clk); #1; lat++; end
        check({tag, " latency"}, lat, elat);
        check({tag, " result"}, h_result, er);
        check({tag, " err/unf/ovf"}, {h_error, h_underflow, h_overflow}, eflags);
        h_out_ready = 1'b1;
        @(posedge clk); #1;
        h_out_ready = 1'b0;
    endtask

    initial begin
        int lat;
        int seen;
        rst_n = 1'b0;
        f_in_valid = 1'b0; f_out_ready = 1'b0; f_op = '0; f_a = '0; f_b = '0;
        h_in_valid = 1'b0; h_out_ready = 1'b0; h_op = '0; h_a = '0; h_b = '0;
        repeat (3) @(posedge clk);
        #1;
        check("reset out_valid", f_out_valid, 0);
        check("reset result", f_result, 0);
        check("reset flags", {f_error, f_underflow, f_overflow}, 0);
        check("reset h out_valid", h_out_valid, 0);
        rst_n = 1'b1;
        @(posedge clk); #1;
        check("post-reset in_ready", f_in_ready, 1);
        check("post-reset h in_ready", h_in_ready, 1);

        do32("add 3.5+2.5", 2'b00, 32'h40600000, 32'h40200000, 32'h40C00000, 3'b000, 4);
        do32("sub 5-1.5",   2'b01, 32'h40A00000, 32'h3FC00000, 32'h40600000, 3'b000, 4);
        do32("sub 1-1",     2'b01, 32'h3F800000, 32'h3F800000, 32'h00000000, 3'b000, 4);
        do32("add inf+1",   2'b00, 32'h7F800000, 32'h3F800000, 32'h7FC00000, 3'b100, 4);
        do32("mul 2*4",     2'b10, 32'h40000000, 32'h40800000, 32'h41000000, 3'b000, 4);
        do32("mul max*max", 2'b10, 32'h7F7FFFFF, 32'h7F7FFFFF, 32'h7F800000, 3'b001, 4);
        do32("mul min*0.5", 2'b10, 32'h00800000, 32'h3F000000, 32'h00000000, 3'b010, 4);
        do32("div 9/3",     2'b11, 32'h41100000, 32'h40400000, 32'h40400000, 3'b000, 30);
        do32("div 2/0",     2'b11, 32'h40000000, 32'h00000000, 32'h7F800000, 3'b100, 30);
        do32("div 0/0",     2'b11, 32'h00000000, 32'h00000000, 32'h7FC00000, 3'b100, 30);

        // Back-pressure: result held for 5 cycles while a new op waits on in_valid.
        issue32(2'b10, 32'h40000000, 32'h40800000);
        wait_out32(lat);
        check("bp latency", lat, 4);
        f_op = 2'b00; f_a = 32'h40600000; f_b = 32'h40200000; f_in_valid = 1'b1;
        for (int i = 0; i < 5; i++) begin
            @(posedge clk); #1;
            check("bp hold out_valid", f_out_valid, 1);
            check("bp hold result", f_result, 32'h41000000);
            check("bp hold in_ready", f_in_ready, 0);
        end
        f_out_ready = 1'b1;
        @(posedge clk); #1;
        f_out_ready = 1'b0;
        check("bp handshake out_valid", f_out_valid, 0);
        check("bp handshake in_ready", f_in_ready, 1);
        @(posedge clk); #1;
        f_in_valid = 1'b0;
        check("bp accepted in_ready", f_in_ready, 0);
        wait_out32(lat);
        check("bp queued latency", lat, 4);
        check("bp queued result", f_result, 32'h40C00000);
        release32();

        // Reset in the middle of a divide.
        issue32(2'b11, 32'h41100000, 32'h40400000);
        repeat (9) @(posedge clk);
        #2;
        check("mid-div in_ready", f_in_ready, 0);
        rst_n = 1'b0;
        #1;
        check("rst async in_ready", f_in_ready, 1);
        check("rst async out_valid", f_out_valid, 0);
        check("rst async result", f_result, 0);
        check("rst async flags", {f_error, f_underflow, f_overflow}, 0);
        repeat (2) @(posedge clk);
        #1;
        rst_n = 1'b1;
        seen = 0;
        for (int i = 0; i < 40; i++) begin
            @(posedge clk); #1;
            if (f_out_valid) seen++;
        end
        check("rst no out_valid", seen, 0);
        check("rst in_ready after", f_in_ready, 1);

        do16("h add 3.5+2.5", 2'b00, 16'h4300, 16'h4100, 16'h4600, 3'b000, 4);
        do16("h div 4/2",     2'b11, 16'h4400, 16'h4000, 16'h4000, 3'b000, 17);

        $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
        $finish;
    end
endmodule
